rob_writeback_arbiter: RTL and testbench
========================================

# rob_writeback_arbiter

Merges the two result streams that complete out of the execution pipelines into the single ROB write port. The streams are the short path (ALU/MEM results leaving the MEM-side register banks) and the long path (results leaving the final multiply stage, MUL5). The multiply path is fixed-latency and can never be stalled, so it always wins the port. Short-path results that collide are held in a small in-order skid FIFO. When that FIFO is full, `mem_load` is dropped to freeze the upstream short-path banks.

## Interface
- `DATA_W`, default 32 (`DATA_SIZE`): result data width.
- `TAG_W`, default 4 (`ROB_WIDTH`): ROB tag width.
- `FIFO_DEPTH`, default 2: skid entries, power of two, ≥2.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `flush`, in, 1: ROB misprediction flush; synchronous; discards all pending results.
- `mem_valid`, in, 1: short-path result present this cycle.
- `mem_tag`, in, TAG_W: ROB tag of the short-path result.
- `mem_data`, in, DATA_W: short-path result value.
- `mul_valid`, in, 1: MUL5 result present this cycle.
- `mul_tag`, in, TAG_W: ROB tag of the MUL5 result.
- `mul_data`, in, DATA_W: MUL5 result value.
- `mem_load`, out, 1: short-path accept. Drives the `load` of the upstream short-path banks; 0 means hold.
- `rob_wr_en`, out, 1: registered ROB write strobe.
- `rob_wr_tag`, out, TAG_W: registered ROB write tag.
- `rob_wr_data`, out, DATA_W: registered ROB write data.
- `pending`, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Accept rule:**
  - `mem_load` = !reset && !flush && (count < FIFO_DEPTH). It is combinational from the registered count only; it never depends on same-cycle dequeue.
  - A short-path result is accepted only when `mem_valid && mem_load`. With `mem_load`=0 the inputs are ignored; upstream holds them.
- **Selection each cycle (priority order):**
  1. `mul_valid`: write the MUL result.
  2. Else FIFO non-empty: write the FIFO head and pop.
  3. Else accepted short-path result: write it directly (bypass, no enqueue).
  4. Else no write.
- **Enqueue:** an accepted short-path result that was not written by rule 3 is pushed at the tail. This happens when the MUL result or the FIFO head took the port.
- **Ordering:** the FIFO head always precedes a new short-path result, so short-path results reach the ROB in acceptance order. MUL results may overtake them; the ROB is tag-indexed, so this is legal.
- **Simultaneous push and pop:** when a new result is accepted while the head pops, count is unchanged and the pointers advance together.
- **Pointers:** wrap modulo FIFO_DEPTH. `pending` = count.
- **MUL during flush:** `mul_valid` with `flush`=1 is dropped. The MUL stage bank is cleared by the same flush.
- **Flush:** clears count and both pointers, and forces `rob_wr_en`=0 next cycle. An accepted input that cycle is impossible because `mem_load`=0.
- **Reset values:** count 0, pointers 0, `rob_wr_en` 0, `rob_wr_tag` 0, `rob_wr_data` 0, `pending` 0. `mem_load` is 0 during reset and 1 in the first cycle after reset.
- **Reset mid-operation:** all FIFO contents are lost and no write is issued in the following cycle.

## Timing
- **Output latency:** `rob_wr_*` are registered. A result selected in cycle N appears on `rob_wr_*` in cycle N+1, with `rob_wr_en` high for exactly one cycle per result.
- **Bypass latency:** a short-path result with an empty FIFO and no MUL conflict takes 1 cycle.
- **Each collision:** adds one FIFO entry.
- **Refilling a full FIFO:** `mem_load` returns to 1 the cycle after the first pop that leaves count < FIFO_DEPTH.
- **Throughput:** exactly one ROB write per cycle whenever any source has data.
- **Data retention:** `rob_wr_tag` and `rob_wr_data` hold their last value when `rob_wr_en`=0. Verification checks them only under `rob_wr_en`.

## Test plan
- **Bypass:** reset, then `mem_valid` with tag 3, data 0x0000_00AA, no MUL.
  - Next cycle: `rob_wr_en`=1, tag 3, data 0xAA.
  - `pending` stays 0 and `mem_load` stays 1 throughout.
- **Collision:** same cycle, `mul_valid` tag 5 data 0x1234 and `mem_valid` tag 6 data 0x5678.
  - Cycle+1: write tag 5.
  - Cycle+2: write tag 6.
  - `pending` is 1 for one cycle.
- **Backpressure:**
  - Stimulus: `mul_valid` every cycle for 4 cycles with tags 1,2,3,4, while `mem_valid` is held with tags 8,9,10.
  - Required: `pending` reaches 2, then `mem_load`=0 while the MUL results keep winning.
  - Tag 10 is accepted only once `mem_load` returns to 1.
  - Required write order: 1,2,3,4,8,9,10, with no loss or duplication.
- **Order under interleave:**
  - Stimulus: alternate MUL and short-path inputs for 20 random cycles.
  - Required: short-path tags exit in acceptance order, and every accepted tag is written exactly once.
- **Flush:** with `pending`=2, assert `flush` for one cycle together with `mul_valid`.
  - Next cycle: `rob_wr_en`=0 and `pending`=0.
  - The two buffered tags are never written.
- **Reset mid-burst:** assert `reset` with `pending`=1 and `rob_wr_en` high.
  - Next cycle: all outputs are 0.
  - `mem_load`=1 in the first cycle after `reset` drops.

Source files
------------

// File: rtl/rob_writeback_arbiter_if.sv
// Bundle of the short-path, MUL5 and ROB write-port signals around rob_writeback_arbiter.
// master drives the result streams; slave is the arbiter itself.
interface rob_writeback_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              mem_valid;
    logic [TAG_W-1:0]  mem_tag;
    logic [DATA_W-1:0] mem_data;
    logic              mem_load;
    logic              mul_valid;
    logic [TAG_W-1:0]  mul_tag;
    logic [DATA_W-1:0] mul_data;
    logic              rob_wr_en;
    logic [TAG_W-1:0]  rob_wr_tag;
    logic [DATA_W-1:0] rob_wr_data;
    logic [CNT_W-1:0]  pending;

    modport master (
        output mem_valid, mem_tag, mem_data, mul_valid, mul_tag, mul_data,
        input  mem_load, rob_wr_en, rob_wr_tag, rob_wr_data, pending
    );

    modport slave (
        input  mem_valid, mem_tag, mem_data, mul_valid, mul_tag, mul_data,
        output mem_load, rob_wr_en, rob_wr_tag, rob_wr_data, pending
    );
endinterface

// File: rtl/rob_writeback_arbiter.sv
// Merges the short-path and MUL5 result streams onto the single ROB write port.
// MUL5 always wins; colliding short-path results wait in an in-order skid FIFO.
module rob_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    rob_writeback_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_en;
    logic [TAG_W-1:0]  r_wr_tag;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_mem_load;
    logic              w_accept;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_sel_en;
    entry_t            w_sel;

    // Accept gating and write-port selection: MUL, then FIFO head, then bypass.
    always_comb begin
        w_empty    = (r_count == CNT_W'(0));
        w_mem_load = !reset && !flush && (r_count < CNT_W'(FIFO_DEPTH));
        w_accept   = bus.mem_valid && w_mem_load;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        w_sel_en   = 1'b0;
        w_sel      = '{tag: {TAG_W{1'b0}}, data: {DATA_W{1'b0}}};
        if (bus.mul_valid) begin
            w_sel_en = 1'b1;
            w_sel    = '{tag: bus.mul_tag, data: bus.mul_data};
            w_push   = w_accept;
        end else if (!w_empty) begin
            w_sel_en = 1'b1;
            w_sel    = r_fifo[r_rd_ptr];
            w_pop    = 1'b1;
            w_push   = w_accept;
        end else if (w_accept) begin
            w_sel_en = 1'b1;
            w_sel    = '{tag: bus.mem_tag, data: bus.mem_data};
        end else begin
            w_sel_en = 1'b0;
        end
    end

    // Skid storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{tag: bus.mem_tag, data: bus.mem_data};
        end
    end

    // FIFO pointers/occupancy and the registered ROB write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_tag  <= {TAG_W{1'b0}};
            r_wr_data <= {DATA_W{1'b0}};
        end else if (flush) begin
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_count   <= {CNT_W{1'b0}};
            r_wr_en   <= 1'b0;
        end else begin
            r_wr_en <= w_sel_en;
            if (w_sel_en) begin
                r_wr_tag  <= w_sel.tag;
                r_wr_data <= w_sel.data;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.mem_load    = w_mem_load;
    assign bus.rob_wr_en   = r_wr_en;
    assign bus.rob_wr_tag  = r_wr_tag;
    assign bus.rob_wr_data = r_wr_data;
    assign bus.pending     = r_count;
endmodule

// File: tb/tb_rob_writeback_arbiter.sv
// Bench for rob_writeback_arbiter: hand-computed vector table for the directed
// scenarios, then a reference model for a random interleave, both via a scoreboard queue.
module tb_rob_writeback_arbiter;
    localparam int DEPTH = 2;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    rob_writeback_arbiter_if #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH)) bus ();

    rob_writeback_arbiter #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        mv;
        logic [3:0]  mtag;
        logic [31:0] mdata;
        logic        uv;
        logic [3:0]  utag;
        logic [31:0] udata;
        logic        exp_load;
        logic        exp_en;
        logic [3:0]  exp_tag;
        logic [31:0] exp_data;
        logic [1:0]  exp_pend;
        logic        chk_td;
    } vec_t;

    typedef struct {
        logic        en;
        logic [3:0]  tag;
        logic [31:0] data;
        logic [1:0]  pend;
        logic        chk_td;
    } exp_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
    } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];

    function automatic vec_t mkv(input int rst, input int fl, input int mv, input int mt,
                                 input logic [31:0] md, input int uv, input int ut,
                                 input logic [31:0] ud, input int ld, input int en,
                                 input int et, input logic [31:0] ed, input int pd,
                                 input int ct);
        vec_t v;
        v.rst = rst[0]; v.fl = fl[0]; v.mv = mv[0]; v.mtag = mt[3:0]; v.mdata = md;
        v.uv = uv[0]; v.utag = ut[3:0]; v.udata = ud;
        v.exp_load = ld[0]; v.exp_en = en[0]; v.exp_tag = et[3:0]; v.exp_data = ed;
        v.exp_pend = pd[1:0]; v.chk_td = ct[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic mv,
                         input logic [3:0] mt, input logic [31:0] md, input logic uv,
                         input logic [3:0] ut, input logic [31:0] ud);
        reset         = rst;
        flush         = fl;
        bus.mem_valid = mv;
        bus.mem_tag   = mt;
        bus.mem_data  = md;
        bus.mul_valid = uv;
        bus.mul_tag   = ut;
        bus.mul_data  = ud;
    endtask

    // Checks mem_load mid-cycle, then the registered outputs just after the edge.
    task automatic finish_cycle(input logic exp_load);
        exp_t e;
        #2;
        chk("mem_load", {31'd0, bus.mem_load}, {31'd0, exp_load});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("rob_wr_en", {31'd0, bus.rob_wr_en}, {31'd0, e.en});
        if (e.en || e.chk_td) begin
            chk("rob_wr_tag", {28'd0, bus.rob_wr_tag}, {28'd0, e.tag});
            chk("rob_wr_data", bus.rob_wr_data, e.data);
        end
        chk("pending", {30'd0, bus.pending}, {30'd0, e.pend});
    endtask

    // Reference behaviour: predicts mem_load and the next-cycle write from the inputs.
    task automatic model_cycle(input logic rst, input logic fl, input logic mv,
                               input logic [3:0] mt, input logic [31:0] md, input logic uv,
                               input logic [3:0] ut, input logic [31:0] ud,
                               output logic accepted);
        exp_t e;
        ent_t h;
        logic ld;
        ld = !rst && !fl && (mq.size() < DEPTH);
        accepted = mv && ld;
        e = '{en: 1'b0, tag: 4'd0, data: 32'd0, pend: 2'd0, chk_td: 1'b0};
        drive(rst, fl, mv, mt, md, uv, ut, ud);
        if (rst) begin
            mq.delete();
            e.chk_td = 1'b1;
        end else if (fl) begin
            mq.delete();
        end else if (uv) begin
            e.en = 1'b1; e.tag = ut; e.data = ud;
            if (accepted) mq.push_back('{tag: mt, data: md});
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e.en = 1'b1; e.tag = h.tag; e.data = h.data;
            if (accepted) mq.push_back('{tag: mt, data: md});
        end else if (accepted) begin
            e.en = 1'b1; e.tag = mt; e.data = md;
        end
        e.pend = 2'(mq.size());
        exp_q.push_back(e);
        finish_cycle(ld);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[23];
        logic acc;
        logic [3:0] next_mtag;
        logic mv, uv;
        checks = 0;
        errors = 0;
        //                rst fl mv mt  mdata          uv ut  udata          ld en et  exp_data       pd ct
        vecs[0]  = mkv(1, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 1);
        vecs[1]  = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 0);
        vecs[2]  = mkv(0, 0, 1, 3,  32'h0000_00AA, 0, 0, 32'h0,        1, 1, 3,  32'h0000_00AA, 0, 0);
        vecs[3]  = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 0);
        vecs[4]  = mkv(0, 0, 1, 6,  32'h5678,     1, 5,  32'h1234,     1, 1, 5,  32'h1234,     1, 0);
        vecs[5]  = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 1, 6,  32'h5678,     0, 0);
        vecs[6]  = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 0);
        vecs[7]  = mkv(0, 0, 1, 8,  32'h208,      1, 1,  32'h101,      1, 1, 1,  32'h101,      1, 0);
        vecs[8]  = mkv(0, 0, 1, 9,  32'h209,      1, 2,  32'h102,      1, 1, 2,  32'h102,      2, 0);
        vecs[9]  = mkv(0, 0, 1, 10, 32'h20A,      1, 3,  32'h103,      0, 1, 3,  32'h103,      2, 0);
        vecs[10] = mkv(0, 0, 1, 10, 32'h20A,      1, 4,  32'h104,      0, 1, 4,  32'h104,      2, 0);
        vecs[11] = mkv(0, 0, 1, 10, 32'h20A,      0, 0,  32'h0,        0, 1, 8,  32'h208,      1, 0);
        vecs[12] = mkv(0, 0, 1, 10, 32'h20A,      0, 0,  32'h0,        1, 1, 9,  32'h209,      1, 0);
        vecs[13] = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 1, 10, 32'h20A,      0, 0);
        vecs[14] = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 0);
        vecs[15] = mkv(0, 0, 1, 11, 32'h20B,      1, 7,  32'h107,      1, 1, 7,  32'h107,      1, 0);
        vecs[16] = mkv(0, 0, 1, 13, 32'h20D,      1, 12, 32'h10C,      1, 1, 12, 32'h10C,      2, 0);
        vecs[17] = mkv(0, 1, 0, 0,  32'h0,        1, 14, 32'h10E,      0, 0, 0,  32'h0,        0, 0);
        vecs[18] = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 0);
        vecs[19] = mkv(0, 0, 1, 2,  32'h202,      1, 1,  32'h101,      1, 1, 1,  32'h101,      1, 0);
        vecs[20] = mkv(1, 0, 0, 0,  32'h0,        1, 3,  32'h103,      0, 0, 0,  32'h0,        0, 1);
        vecs[21] = mkv(0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 1);
        vecs[22] = mkv(0, 0, 1, 15, 32'h20F,      0, 0,  32'h0,        1, 1, 15, 32'h20F,      0, 0);

        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        #1;
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].mv, vecs[i].mtag, vecs[i].mdata,
                  vecs[i].uv, vecs[i].utag, vecs[i].udata);
            exp_q.push_back('{en: vecs[i].exp_en, tag: vecs[i].exp_tag,
                              data: vecs[i].exp_data, pend: vecs[i].exp_pend,
                              chk_td: vecs[i].chk_td});
            finish_cycle(vecs[i].exp_load);
        end

        // Random interleave; a short-path tag advances only once it has been accepted.
        next_mtag = 4'd1;
        for (int i = 0; i < 20; i++) begin
            uv = (i % 2 == 0) || ($urandom_range(0, 3) == 0);
            mv = (i % 2 == 1) || ($urandom_range(0, 2) == 0);
            model_cycle(1'b0, 1'b0, mv, next_mtag, {28'h0000_A00, next_mtag}, uv,
                        4'($urandom_range(0, 15)), $urandom, acc);
            if (acc) next_mtag = next_mtag + 4'd1;
        end
        for (int i = 0; i < 4; i++) begin
            model_cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
